// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: drives an SRAM-like data bus and fills the W-stage registers.
// Optional ADDR_EXC_EN: detect misaligned halfword/word accesses and raise adelW/adesW instead of issuing them.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memenM,
    input  logic [5:0]  opM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stallM,
    output logic        validW,
    output logic [5:0]  opW,
    output logic [31:0] aluoutW,
    output logic [31:0] lwresultW,
    output logic        adelW,
    output logic        adesW
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} stateT;

    stateT state, stateNext;

    logic       isStore;
    logic       misaligned;
    logic       start;
    logic       loadDone;
    logic       memValid;
    logic [3:0] wstrbNext;
    logic [31:0] wdataNext;

    assign isStore = (opM == OP_SB) | (opM == OP_SH) | (opM == OP_SW);

`ifdef ADDR_EXC_EN
    logic isHalf;
    logic isWord;
    assign isHalf     = (opM == OP_LH) | (opM == OP_LHU) | (opM == OP_SH);
    assign isWord     = (opM == OP_LW) | (opM == OP_SW);
    assign misaligned = (isHalf & aluoutM[0]) | (isWord & (aluoutM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign memValid = memenM & ~flushM;
    assign start    = memValid & ~misaligned;

    // Byte lanes and replicated store data; loads leave all strobes clear.
    always_comb begin
        wstrbNext = 4'b0000;
        wdataNext = writedataM;
        case (opM)
            OP_SB: begin
                wstrbNext = 4'b0001 << aluoutM[1:0];
                wdataNext = {4{writedataM[7:0]}};
            end
            OP_SH: begin
                wstrbNext = aluoutM[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{writedataM[15:0]}};
            end
            OP_SW: wstrbNext = 4'b1111;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stallM    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = ADDR;
                    stallM    = 1'b1;
                end
            end
            ADDR: begin
                stallM = 1'b1;
                if (data_addr_ok)  stateNext = DATA;
                else if (flushM)   stateNext = IDLE;
            end
            DATA: begin
                if (data_data_ok) stateNext = IDLE;
                else begin
                    stallM = 1'b1;
                    if (flushM) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                stallM = 1'b1;
                if (data_data_ok) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign data_req = (state == ADDR);
    assign loadDone = (state == DATA) & data_data_ok & ~data_wr;

    // Request is captured once so the bus sees stable fields while M is frozen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_wr    <= 1'b0;
            data_wstrb <= 4'b0000;
            data_addr  <= 32'h0;
            data_wdata <= 32'h0;
        end else if (state == IDLE && start) begin
            data_wr    <= isStore;
            data_wstrb <= wstrbNext;
            data_addr  <= {aluoutM[31:2], 2'b00};
            data_wdata <= wdataNext;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            validW    <= 1'b0;
            opW       <= 6'h0;
            aluoutW   <= 32'h0;
            lwresultW <= 32'h0;
            adelW     <= 1'b0;
            adesW     <= 1'b0;
        end else if (stallM) begin
            validW <= 1'b0;
            adelW  <= 1'b0;
            adesW  <= 1'b0;
        end else begin
            validW    <= memValid;
            opW       <= opM;
            aluoutW   <= aluoutM;
            lwresultW <= loadDone ? data_rdata : 32'h0;
            adelW     <= memValid & misaligned & ~isStore;
            adesW     <= memValid & misaligned & isStore;
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, corner sequences, randomized traffic.
module tb_lsu_mem_stage;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        memenM = 1'b0;
    logic [5:0]  opM = 6'h0;
    logic [31:0] aluoutM = 32'h0;
    logic [31:0] writedataM = 32'h0;
    logic        flushM = 1'b0;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic        stallM, validW, adelW, adesW;
    logic [5:0]  opW;
    logic [31:0] aluoutW, lwresultW;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage dut (
        .clk(clk), .resetn(resetn), .memenM(memenM), .opM(opM), .aluoutM(aluoutM),
        .writedataM(writedataM), .flushM(flushM), .data_req(data_req), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallM(stallM), .validW(validW), .opW(opW), .aluoutW(aluoutW),
        .lwresultW(lwresultW), .adelW(adelW), .adesW(adesW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the bus should see for an access, from the ISA-level rules.
    function automatic void refModel(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic mis,
                                     output logic [3:0] strb, output logic [31:0] wdata);
        int unsigned off;
        bit excEn;
`ifdef ADDR_EXC_EN
        excEn = 1'b1;
`else
        excEn = 1'b0;
`endif
        off   = addr % 4;
        mis   = 1'b0;
        strb  = 4'h0;
        wdata = wd;
        case (op)
            OP_SB: begin
                strb  = 4'(1 << off);
                wdata = (wd % 256) * 32'h01010101;
            end
            OP_SH: begin
                strb  = (off >= 2) ? 4'hC : 4'h3;
                wdata = (wd % 65536) * 32'h00010001;
                mis   = excEn && (off % 2 != 0);
            end
            OP_SW: begin
                strb = 4'hF;
                mis  = excEn && (off != 0);
            end
            OP_LH, OP_LHU: mis = excEn && (off % 2 != 0);
            OP_LW:         mis = excEn && (off != 0);
            default: ;
        endcase
    endfunction

    // Entered just after a rising edge with the FSM idle; leaves it idle the same way.
    task automatic runTxn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int aDly, input int dDly,
                          input logic [31:0] rdata, input logic expMis,
                          input logic [3:0] expStrb, input logic [31:0] expWdata);
        logic st;
        st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        memenM = 1'b1; opM = op; aluoutM = addr; writedataM = wd; flushM = 1'b0;
        if (expMis) begin
            @(negedge clk);
            chk({tag, " mis stallM"}, stallM, 0);
            chk({tag, " mis data_req"}, data_req, 0);
            @(posedge clk); #1;
            memenM = 1'b0;
            chk({tag, " mis validW"}, validW, 1);
            chk({tag, " adelW"}, adelW, !st);
            chk({tag, " adesW"}, adesW, st);
            chk({tag, " mis lwresultW"}, lwresultW, 0);
        end else begin
            @(negedge clk);
            chk({tag, " start stallM"}, stallM, 1);
            chk({tag, " start data_req"}, data_req, 0);
            @(posedge clk); #1;
            for (int k = 0; k <= aDly; k++) begin
                data_addr_ok = (k == aDly);
                @(negedge clk);
                chk({tag, " data_req"}, data_req, 1);
                chk({tag, " addr stallM"}, stallM, 1);
                chk({tag, " bubble validW"}, validW, 0);
                if (k == 0) begin
                    chk({tag, " data_addr"}, data_addr, addr & 32'hFFFF_FFFC);
                    chk({tag, " data_wr"}, data_wr, st);
                    chk({tag, " data_wstrb"}, data_wstrb, expStrb);
                    if (st) chk({tag, " data_wdata"}, data_wdata, expWdata);
                end
                @(posedge clk); #1;
            end
            data_addr_ok = 1'b0;
            for (int k = 0; k <= dDly; k++) begin
                data_data_ok = (k == dDly);
                data_rdata   = (k == dDly) ? rdata : $urandom;
                @(negedge clk);
                chk({tag, " data data_req"}, data_req, 0);
                chk({tag, " data stallM"}, stallM, k != dDly);
                @(posedge clk); #1;
            end
            data_data_ok = 1'b0;
            memenM = 1'b0;
            chk({tag, " validW"}, validW, 1);
            chk({tag, " opW"}, opW, op);
            chk({tag, " aluoutW"}, aluoutW, addr);
            chk({tag, " lwresultW"}, lwresultW, st ? 32'h0 : rdata);
            chk({tag, " adelW"}, adelW, 0);
            chk({tag, " adesW"}, adesW, 0);
        end
    endtask

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        int          aDly;
        int          dDly;
        logic [31:0] rdata;
        logic        expMis;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
    } vecT;

    vecT vecs[9];
    logic [5:0] opList[8];

    initial begin
        vecs[0] = '{"lw1000", OP_LW, 32'h1000, 32'h0, 0, 2, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0};
        vecs[1] = '{"sb2003", OP_SB, 32'h2003, 32'hA5, 0, 0, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5};
`ifdef ADDR_EXC_EN
        vecs[2] = '{"lh3001", OP_LH, 32'h3001, 32'h0, 1, 0, 32'h0000CAFE, 1'b1, 4'h0, 32'h0};
        vecs[3] = '{"sw3002", OP_SW, 32'h3002, 32'h11223344, 0, 0, 32'h0, 1'b1, 4'h0, 32'h0};
`else
        vecs[2] = '{"lh3001", OP_LH, 32'h3001, 32'h0, 1, 0, 32'h0000CAFE, 1'b0, 4'h0, 32'h0};
        vecs[3] = '{"sw3002", OP_SW, 32'h3002, 32'h11223344, 0, 0, 32'h0, 1'b0, 4'hF, 32'h11223344};
`endif
        vecs[4] = '{"sh2002", OP_SH, 32'h2002, 32'hABCD1234, 2, 1, 32'h0, 1'b0, 4'hC, 32'h12341234};
        vecs[5] = '{"sh2000", OP_SH, 32'h2000, 32'h0000BEEF, 0, 0, 32'h0, 1'b0, 4'h3, 32'hBEEFBEEF};
        vecs[6] = '{"lbu2001", OP_LBU, 32'h2001, 32'h0, 0, 0, 32'h55667788, 1'b0, 4'h0, 32'h0};
        vecs[7] = '{"sw0ffc", OP_SW, 32'h0FFC, 32'hCAFEF00D, 1, 3, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D};
        vecs[8] = '{"lw6004", OP_LW, 32'h6004, 32'h0, 0, 1, 32'h87654321, 1'b0, 4'h0, 32'h0};
        opList = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        // Reset state
        #1 resetn = 1'b0;
        #2;
        chk("rst data_req", data_req, 0);
        chk("rst data_wr", data_wr, 0);
        chk("rst data_wstrb", data_wstrb, 0);
        chk("rst data_addr", data_addr, 0);
        chk("rst data_wdata", data_wdata, 0);
        chk("rst stallM", stallM, 0);
        chk("rst validW", validW, 0);
        chk("rst opW", opW, 0);
        chk("rst aluoutW", aluoutW, 0);
        chk("rst lwresultW", lwresultW, 0);
        chk("rst adelW", adelW, 0);
        chk("rst adesW", adesW, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            runTxn(vecs[i].tag, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].aDly,
                   vecs[i].dDly, vecs[i].rdata, vecs[i].expMis, vecs[i].expStrb, vecs[i].expWdata);

        // Flush while waiting for data: drain the response and retire nothing.
        memenM = 1'b1; opM = OP_LW; aluoutM = 32'h5000;
        @(negedge clk); @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        data_addr_ok = 1'b0; flushM = 1'b1;
        @(negedge clk);
        chk("drain flush stallM", stallM, 1);
        @(posedge clk); #1;
        flushM = 1'b0; memenM = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drain wait stallM", stallM, 1);
            chk("drain wait data_req", data_req, 0);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        @(negedge clk);
        chk("drain ok stallM", stallM, 1);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("drain bubble validW", validW, 0);
        @(negedge clk);
        chk("drain done stallM", stallM, 0);
        @(posedge clk); #1;
        chk("drain validW", validW, 0);
        chk("drain lwresultW", lwresultW, 0);

        // Flush while the request is pending: request withdrawn.
        memenM = 1'b1; opM = OP_SW; aluoutM = 32'h5100; writedataM = 32'h1;
        @(negedge clk); @(posedge clk); #1;
        flushM = 1'b1;
        @(negedge clk);
        chk("wd data_req", data_req, 1);
        chk("wd stallM", stallM, 1);
        @(posedge clk); #1;
        flushM = 1'b0; memenM = 1'b0;
        @(negedge clk);
        chk("wd idle data_req", data_req, 0);
        chk("wd idle stallM", stallM, 0);
        @(posedge clk); #1;
        chk("wd validW", validW, 0);

        // Flush in IDLE suppresses start and exception flags.
        memenM = 1'b1; flushM = 1'b1; opM = OP_LH; aluoutM = 32'h3001;
        @(negedge clk);
        chk("fidle stallM", stallM, 0);
        chk("fidle data_req", data_req, 0);
        @(posedge clk); #1;
        memenM = 1'b0; flushM = 1'b0;
        chk("fidle validW", validW, 0);
        chk("fidle adelW", adelW, 0);

        // Reset during ADDR, then a stray data_ok must be ignored.
        memenM = 1'b1; opM = OP_LW; aluoutM = 32'h4000;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rstaddr data_req", data_req, 1);
        #1 resetn = 1'b0; memenM = 1'b0;
        #1;
        chk("rstaddr data_req low", data_req, 0);
        chk("rstaddr stallM", stallM, 0);
        chk("rstaddr data_addr", data_addr, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("stray stallM", stallM, 0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("stray validW", validW, 0);
        chk("stray lwresultW", lwresultW, 0);
        chk("stray data_req", data_req, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  op;
            logic [31:0] addr, wd, rd, expWdata;
            logic        mis;
            logic [3:0]  strb;
            if ($urandom_range(0, 3) == 0) begin
                memenM = 1'b0; opM = 6'($urandom);
                @(negedge clk);
                chk("rnd idle stallM", stallM, 0);
                @(posedge clk); #1;
                chk("rnd idle validW", validW, 0);
            end
            op   = opList[$urandom_range(0, 7)];
            addr = $urandom & 32'h0000FFFF;
            wd   = $urandom;
            rd   = $urandom;
            refModel(op, addr, wd, mis, strb, expWdata);
            runTxn("rnd", op, addr, wd, $urandom_range(0, 3), $urandom_range(0, 3),
                   rd, mis, strb, expWdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
